// File: rtl/rv32i_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv32i_pkg
// Description : Shared opcode/funct3 constants, FSM state and ALU op types
//               for the multicycle RV32I core.
// Revision    : 1.0
// ============================================================================
package rv32i_pkg;

    localparam logic [6:0] c_opc_lui    = 7'b0110111;
    localparam logic [6:0] c_opc_auipc  = 7'b0010111;
    localparam logic [6:0] c_opc_jal    = 7'b1101111;
    localparam logic [6:0] c_opc_jalr   = 7'b1100111;
    localparam logic [6:0] c_opc_branch = 7'b1100011;
    localparam logic [6:0] c_opc_load   = 7'b0000011;
    localparam logic [6:0] c_opc_store  = 7'b0100011;
    localparam logic [6:0] c_opc_opimm  = 7'b0010011;
    localparam logic [6:0] c_opc_op     = 7'b0110011;

    localparam logic [2:0] c_f3_add  = 3'b000;
    localparam logic [2:0] c_f3_sll  = 3'b001;
    localparam logic [2:0] c_f3_slt  = 3'b010;
    localparam logic [2:0] c_f3_sltu = 3'b011;
    localparam logic [2:0] c_f3_xor  = 3'b100;
    localparam logic [2:0] c_f3_sr   = 3'b101;
    localparam logic [2:0] c_f3_or   = 3'b110;
    localparam logic [2:0] c_f3_and  = 3'b111;

    localparam logic [2:0] c_f3_beq  = 3'b000;
    localparam logic [2:0] c_f3_bne  = 3'b001;
    localparam logic [2:0] c_f3_blt  = 3'b100;
    localparam logic [2:0] c_f3_bge  = 3'b101;
    localparam logic [2:0] c_f3_bltu = 3'b110;
    localparam logic [2:0] c_f3_bgeu = 3'b111;

    localparam logic [2:0] c_f3_lb  = 3'b000;
    localparam logic [2:0] c_f3_lh  = 3'b001;
    localparam logic [2:0] c_f3_lbu = 3'b100;
    localparam logic [2:0] c_f3_lhu = 3'b101;

    typedef enum logic [2:0] {
        ST_FETCH = 3'd0,
        ST_IWAIT = 3'd1,
        ST_EXEC  = 3'd2,
        ST_MEM   = 3'd3,
        ST_DWAIT = 3'd4
    } cpu_state_t;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_t;

endpackage
`default_nettype wire

// File: rtl/rv32i_alu.sv
`default_nettype none
// ============================================================================
// Module      : rv32i_alu
// Description : Combinational RV32I ALU with branch condition evaluation.
// Revision    : 1.0
// ============================================================================
module rv32i_alu
    import rv32i_pkg::*;
(
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  alu_op_t     i_op,
    input  logic [2:0]  i_br_funct3,
    output logic [31:0] o_result,
    output logic        o_br_taken
);

    logic w_eq;
    logic w_lt_s;
    logic w_lt_u;

    assign w_eq   = (i_a == i_b);
    assign w_lt_s = ($signed(i_a) < $signed(i_b));
    assign w_lt_u = (i_a < i_b);

    always_comb begin
        o_result = '0;
        case (i_op)
            ALU_ADD:  o_result = i_a + i_b;
            ALU_SUB:  o_result = i_a - i_b;
            ALU_SLL:  o_result = i_a << i_b[4:0];
            ALU_SLT:  o_result = {31'b0, w_lt_s};
            ALU_SLTU: o_result = {31'b0, w_lt_u};
            ALU_XOR:  o_result = i_a ^ i_b;
            ALU_SRL:  o_result = i_a >> i_b[4:0];
            ALU_SRA:  o_result = $unsigned($signed(i_a) >>> i_b[4:0]);
            ALU_OR:   o_result = i_a | i_b;
            ALU_AND:  o_result = i_a & i_b;
            default:  o_result = '0;
        endcase
    end

    always_comb begin
        o_br_taken = 1'b0;
        case (i_br_funct3)
            c_f3_beq:  o_br_taken = w_eq;
            c_f3_bne:  o_br_taken = ~w_eq;
            c_f3_blt:  o_br_taken = w_lt_s;
            c_f3_bge:  o_br_taken = ~w_lt_s;
            c_f3_bltu: o_br_taken = w_lt_u;
            c_f3_bgeu: o_br_taken = ~w_lt_u;
            default:   o_br_taken = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/rv32i_cpu.sv
`default_nettype none
// ============================================================================
// Module      : rv32i_cpu
// Description : Multicycle RV32I core with separate wait-request instruction
//               and data buses (word addressed, one-cycle read latency).
// Revision    : 1.0
// ============================================================================
module rv32i_cpu
    import rv32i_pkg::*;
#(
    parameter logic [31:0] INITIAL_PC_VALUE = 32'h00000000
) (
    input  logic        i_Clk,
    input  logic        i_Reset,
    output logic [29:0] o_IBus_Address,
    output logic        o_IBus_Read,
    input  logic [31:0] i_IBus_ReadData,
    input  logic        i_IBus_WaitReq,
    output logic [29:0] o_DBus_Address,
    output logic [3:0]  o_DBus_ByteEn,
    output logic        o_DBus_Read,
    output logic        o_DBus_Write,
    input  logic [31:0] i_DBus_ReadData,
    output logic [31:0] o_DBus_WriteData,
    input  logic        i_DBus_WaitRequest
);

    cpu_state_t  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] regs_q [0:31];
    logic [31:0] regs_d [0:31];

    logic [6:0]  w_opcode;
    logic [4:0]  w_rd, w_rs1_idx, w_rs2_idx;
    logic [2:0]  w_f3;
    logic        w_f7b5;
    logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
    logic [31:0] w_rs1, w_rs2;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_ea;
    logic        w_is_load, w_is_store;
    alu_op_t     w_alu_op;
    logic [31:0] w_alu_b, w_alu_result;
    logic        w_br_taken;
    logic [3:0]  w_lane_be;
    logic [31:0] w_store_data;
    logic [7:0]  w_ld_byte;
    logic [15:0] w_ld_half;
    logic [31:0] w_load_data;
    logic        w_rf_we;
    logic [31:0] w_rf_wd;
    logic        w_fetch_req, w_mem_req;

    assign w_opcode  = ir_q[6:0];
    assign w_rd      = ir_q[11:7];
    assign w_f3      = ir_q[14:12];
    assign w_rs1_idx = ir_q[19:15];
    assign w_rs2_idx = ir_q[24:20];
    assign w_f7b5    = ir_q[30];

    assign w_imm_i = {{20{ir_q[31]}}, ir_q[31:20]};
    assign w_imm_s = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
    assign w_imm_b = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
    assign w_imm_u = {ir_q[31:12], 12'b0};
    assign w_imm_j = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};

    assign w_rs1 = (w_rs1_idx == 5'd0) ? 32'd0 : regs_q[w_rs1_idx];
    assign w_rs2 = (w_rs2_idx == 5'd0) ? 32'd0 : regs_q[w_rs2_idx];

    assign w_pc_plus4 = pc_q + 32'd4;
    assign w_is_load  = (w_opcode == c_opc_load);
    assign w_is_store = (w_opcode == c_opc_store);
    // IR and registers are frozen from EXEC through DWAIT, so EA stays stable while stalled.
    assign w_ea       = w_rs1 + (w_is_store ? w_imm_s : w_imm_i);

    always_comb begin
        w_alu_b  = w_imm_i;
        w_alu_op = ALU_ADD;
        if (w_opcode == c_opc_op || w_opcode == c_opc_branch) begin
            w_alu_b = w_rs2;
        end
        case (w_f3)
            c_f3_add:  w_alu_op = (w_opcode == c_opc_op && w_f7b5) ? ALU_SUB : ALU_ADD;
            c_f3_sll:  w_alu_op = ALU_SLL;
            c_f3_slt:  w_alu_op = ALU_SLT;
            c_f3_sltu: w_alu_op = ALU_SLTU;
            c_f3_xor:  w_alu_op = ALU_XOR;
            c_f3_sr:   w_alu_op = w_f7b5 ? ALU_SRA : ALU_SRL;
            c_f3_or:   w_alu_op = ALU_OR;
            c_f3_and:  w_alu_op = ALU_AND;
            default:   w_alu_op = ALU_ADD;
        endcase
    end

    rv32i_alu u_alu (
        .i_a         (w_rs1),
        .i_b         (w_alu_b),
        .i_op        (w_alu_op),
        .i_br_funct3 (w_f3),
        .o_result    (w_alu_result),
        .o_br_taken  (w_br_taken)
    );

    always_comb begin
        w_lane_be    = 4'b1111;
        w_store_data = w_rs2;
        case (w_f3[1:0])
            2'b00: begin
                w_lane_be    = 4'b0001 << w_ea[1:0];
                w_store_data = {4{w_rs2[7:0]}};
            end
            2'b01: begin
                w_lane_be    = w_ea[1] ? 4'b1100 : 4'b0011;
                w_store_data = {2{w_rs2[15:0]}};
            end
            default: begin
                w_lane_be    = 4'b1111;
                w_store_data = w_rs2;
            end
        endcase
    end

    always_comb begin
        w_ld_byte = i_DBus_ReadData[7:0];
        case (w_ea[1:0])
            2'b00:   w_ld_byte = i_DBus_ReadData[7:0];
            2'b01:   w_ld_byte = i_DBus_ReadData[15:8];
            2'b10:   w_ld_byte = i_DBus_ReadData[23:16];
            default: w_ld_byte = i_DBus_ReadData[31:24];
        endcase
        w_ld_half = w_ea[1] ? i_DBus_ReadData[31:16] : i_DBus_ReadData[15:0];
        case (w_f3)
            c_f3_lb:  w_load_data = {{24{w_ld_byte[7]}}, w_ld_byte};
            c_f3_lh:  w_load_data = {{16{w_ld_half[15]}}, w_ld_half};
            c_f3_lbu: w_load_data = {24'b0, w_ld_byte};
            c_f3_lhu: w_load_data = {16'b0, w_ld_half};
            default:  w_load_data = i_DBus_ReadData;
        endcase
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        w_rf_we = 1'b0;
        w_rf_wd = '0;
        case (state_q)
            ST_FETCH: begin
                if (!i_IBus_WaitReq) state_d = ST_IWAIT;
            end
            ST_IWAIT: begin
                ir_d    = i_IBus_ReadData;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                pc_d    = w_pc_plus4;
                state_d = ST_FETCH;
                case (w_opcode)
                    c_opc_lui: begin
                        w_rf_we = 1'b1;
                        w_rf_wd = w_imm_u;
                    end
                    c_opc_auipc: begin
                        w_rf_we = 1'b1;
                        w_rf_wd = pc_q + w_imm_u;
                    end
                    c_opc_jal: begin
                        w_rf_we = 1'b1;
                        w_rf_wd = w_pc_plus4;
                        pc_d    = pc_q + w_imm_j;
                    end
                    c_opc_jalr: begin
                        w_rf_we = 1'b1;
                        w_rf_wd = w_pc_plus4;
                        pc_d    = {w_ea[31:1], 1'b0};
                    end
                    c_opc_branch: begin
                        if (w_br_taken) pc_d = pc_q + w_imm_b;
                    end
                    c_opc_opimm, c_opc_op: begin
                        w_rf_we = 1'b1;
                        w_rf_wd = w_alu_result;
                    end
                    c_opc_load, c_opc_store: begin
                        state_d = ST_MEM;
                    end
                    default: ;
                endcase
            end
            ST_MEM: begin
                if (!i_DBus_WaitRequest) state_d = w_is_load ? ST_DWAIT : ST_FETCH;
            end
            ST_DWAIT: begin
                w_rf_we = 1'b1;
                w_rf_wd = w_load_data;
                state_d = ST_FETCH;
            end
            default: state_d = ST_FETCH;
        endcase
    end

    always_comb begin
        regs_d = regs_q;
        if (w_rf_we && w_rd != 5'd0) regs_d[w_rd] = w_rf_wd;
        regs_d[0] = '0;
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q <= ST_FETCH;
            pc_q    <= INITIAL_PC_VALUE;
            ir_q    <= '0;
            for (int i = 0; i < 32; i++) regs_q[i] <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            regs_q  <= regs_d;
        end
    end

    // Requests are masked during reset so an in-flight access is abandoned immediately.
    assign w_fetch_req = (state_q == ST_FETCH) && !i_Reset;
    assign w_mem_req   = (state_q == ST_MEM) && !i_Reset;

    assign o_IBus_Read      = w_fetch_req;
    assign o_IBus_Address   = pc_q[31:2];
    assign o_DBus_Read      = w_mem_req && w_is_load;
    assign o_DBus_Write     = w_mem_req && w_is_store;
    assign o_DBus_ByteEn    = w_mem_req ? w_lane_be : 4'b0000;
    assign o_DBus_Address   = w_ea[31:2];
    assign o_DBus_WriteData = w_store_data;

endmodule
`default_nettype wire

// File: tb/tb_rv32i_cpu.sv
`default_nettype none
// ============================================================================
// Module      : tb_rv32i_cpu
// Description : Directed self-checking bench for rv32i_cpu with bus models.
// Revision    : 1.0
// ============================================================================
module tb_rv32i_cpu;

    localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111, OP_BR = 7'b1100011, OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011, OP_IMM = 7'b0010011, OP_REG = 7'b0110011;
    localparam logic [31:0] INIT_PC = 32'h00000000;

    typedef struct {
        logic [29:0] a;
        logic [3:0]  be;
        logic [31:0] d;
        int          c;
    } wr_t;

    logic        i_Clk = 1'b0;
    logic        i_Reset = 1'b1;
    logic [29:0] o_IBus_Address;
    logic        o_IBus_Read;
    logic [31:0] ibus_rdata = '0;
    logic        ibus_wait = 1'b0;
    logic [29:0] o_DBus_Address;
    logic [3:0]  o_DBus_ByteEn;
    logic        o_DBus_Read;
    logic        o_DBus_Write;
    logic [31:0] dbus_rdata = '0;
    logic [31:0] o_DBus_WriteData;
    logic        dbus_wait = 1'b0;

    logic [31:0] imem [0:255];
    logic [31:0] dmem [0:1023];
    logic [29:0] f_addr [$];
    int          f_cyc [$];
    logic [29:0] r_addr [$];
    int          r_cyc [$];
    wr_t         wr_q [$];
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    int          pidx = 0;
    int          jidx;

    rv32i_cpu #(.INITIAL_PC_VALUE(INIT_PC)) dut (
        .i_Clk              (i_Clk),
        .i_Reset            (i_Reset),
        .o_IBus_Address     (o_IBus_Address),
        .o_IBus_Read        (o_IBus_Read),
        .i_IBus_ReadData    (ibus_rdata),
        .i_IBus_WaitReq     (ibus_wait),
        .o_DBus_Address     (o_DBus_Address),
        .o_DBus_ByteEn      (o_DBus_ByteEn),
        .o_DBus_Read        (o_DBus_Read),
        .o_DBus_Write       (o_DBus_Write),
        .i_DBus_ReadData    (dbus_rdata),
        .o_DBus_WriteData   (o_DBus_WriteData),
        .i_DBus_WaitRequest (dbus_wait)
    );

    always #5 i_Clk = ~i_Clk;

    // Bus slaves: one-cycle read latency, accesses above word 1023 are logged only.
    always @(posedge i_Clk) begin
        cyc <= cyc + 1;
        if (o_IBus_Read && !ibus_wait) begin
            ibus_rdata <= imem[o_IBus_Address[7:0]];
            f_addr.push_back(o_IBus_Address);
            f_cyc.push_back(cyc);
        end
        if (o_DBus_Read && !dbus_wait) begin
            dbus_rdata <= (o_DBus_Address[29:10] == 20'd0) ? dmem[o_DBus_Address[9:0]] : 32'h0;
            r_addr.push_back(o_DBus_Address);
            r_cyc.push_back(cyc);
        end
        if (o_DBus_Write && !dbus_wait) begin
            wr_q.push_back('{a: o_DBus_Address, be: o_DBus_ByteEn, d: o_DBus_WriteData, c: cyc});
            if (o_DBus_Address[29:10] == 20'd0)
                for (int b = 0; b < 4; b++)
                    if (o_DBus_ByteEn[b]) dmem[o_DBus_Address[9:0]][8*b +: 8] <= o_DBus_WriteData[8*b +: 8];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], OP_ST};
    endfunction
    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OP_BR};
    endfunction
    function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd, input logic [6:0] op);
        return {imm, rd, op};
    endfunction
    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
    endfunction
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, OP_REG};
    endfunction

    function automatic wr_t wr_at(input int i);
        wr_t z;
        z = '{a: '0, be: '0, d: '0, c: -1000};
        if (i >= 0 && i < wr_q.size()) z = wr_q[i];
        return z;
    endfunction
    function automatic int fc_at(input int i);
        return (i >= 0 && i < f_cyc.size()) ? f_cyc[i] : -1000;
    endfunction
    function automatic logic [31:0] fa_at(input int i);
        return (i >= 0 && i < f_addr.size()) ? {2'b00, f_addr[i]} : 32'hFFFFFFFF;
    endfunction

    task automatic emit(input logic [31:0] w);
        imem[pidx[7:0]] = w;
        pidx++;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) imem[i] = 32'h0;
        for (int i = 0; i < 1024; i++) dmem[i] = 32'h0;
        pidx = 0;
    endtask

    task automatic clear_logs();
        f_addr.delete(); f_cyc.delete(); r_addr.delete(); r_cyc.delete(); wr_q.delete();
    endtask

    task automatic do_reset();
        @(negedge i_Clk);
        i_Reset = 1'b1; ibus_wait = 1'b0; dbus_wait = 1'b0;
        repeat (2) @(negedge i_Clk);
        clear_logs();
        i_Reset = 1'b0;
    endtask

    // kind 0: fetch of word 1; kind 1: store request; otherwise: load request without stall
    task automatic wait_cond(input int kind, input string tag);
        bit hit;
        hit = 1'b0;
        for (int k = 0; k < 300 && !hit; k++) begin
            @(negedge i_Clk);
            case (kind)
                0:       hit = o_IBus_Read && (o_IBus_Address == 30'd1);
                1:       hit = o_DBus_Write;
                default: hit = o_DBus_Read && !dbus_wait;
            endcase
        end
        check_eq(tag, {31'b0, hit}, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        wr_t w;
        // ---------------- reset state + spec loop program ----------------
        clear_mem();
        emit(enc_u(20'hB0000, 5'd2, OP_LUI));
        emit(enc_i(12'd5, 5'd0, 3'd0, 5'd4, OP_IMM));
        emit(enc_i(12'd0, 5'd0, 3'd0, 5'd5, OP_IMM));
        emit(enc_s(12'd0, 5'd2, 5'd2, 3'd0));
        emit(enc_i(12'd1, 5'd5, 3'd0, 5'd5, OP_IMM));
        emit(enc_b(13'h1FF8, 5'd5, 5'd4, 3'd1));
        emit(enc_i(12'd0, 5'd0, 3'd2, 5'd3, OP_LD));
        emit(enc_s(12'd0, 5'd3, 5'd2, 3'd0));
        emit(enc_j(21'd0, 5'd0));
        dmem[0] = 32'd8;
        i_Reset = 1'b1;
        repeat (3) @(negedge i_Clk);
        check_eq("rst_ibus_read", {31'b0, o_IBus_Read}, 32'd0);
        check_eq("rst_dbus_read", {31'b0, o_DBus_Read}, 32'd0);
        check_eq("rst_dbus_write", {31'b0, o_DBus_Write}, 32'd0);
        check_eq("rst_dbus_be", {28'b0, o_DBus_ByteEn}, 32'd0);
        clear_logs();
        i_Reset = 1'b0;
        repeat (150) @(negedge i_Clk);
        check_eq("first_fetch_addr", fa_at(0), {2'b00, INIT_PC[31:2]});
        check_eq("alu_fetch_gap0", fc_at(1) - fc_at(0), 32'd3);
        check_eq("alu_fetch_gap1", fc_at(2) - fc_at(1), 32'd3);
        check_eq("loop_wr_count", wr_q.size(), 32'd6);
        for (int i = 0; i < 5; i++) begin
            w = wr_at(i);
            check_eq($sformatf("loop_wr%0d_addr", i), {2'b00, w.a}, 32'h2C000000);
            check_eq($sformatf("loop_wr%0d_be", i), {28'b0, w.be}, 32'h1);
            check_eq($sformatf("loop_wr%0d_data", i), w.d, 32'h0);
        end
        check_eq("loop_rd_count", r_addr.size(), 32'd1);
        if (r_addr.size() > 0) begin
            check_eq("loop_rd_addr", {2'b00, r_addr[0]}, 32'd0);
            check_eq("loop_rd_order", {31'b0, (r_cyc[0] > wr_at(4).c) && (r_cyc[0] < wr_at(5).c)}, 32'd1);
        end
        w = wr_at(5);
        check_eq("loop_wr5_addr", {2'b00, w.a}, 32'h2C000000);
        check_eq("loop_wr5_be", {28'b0, w.be}, 32'h1);
        check_eq("loop_wr5_data", w.d, 32'h08080808);
        check_eq("spin_last", fa_at(f_addr.size() - 1), 32'h8);
        check_eq("spin_prev", fa_at(f_addr.size() - 2), 32'h8);

        // ---------------- wait states ----------------
        clear_mem();
        emit(enc_i(12'h055, 5'd0, 3'd0, 5'd1, OP_IMM));
        emit(enc_s(12'h040, 5'd1, 5'd0, 3'd2));
        emit(enc_j(21'd0, 5'd0));
        do_reset();
        wait_cond(0, "ws_fetch_seen");
        ibus_wait = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge i_Clk);
            check_eq($sformatf("ws_ifetch_hold%0d", k), {1'b0, o_IBus_Read, o_IBus_Address}, {2'b01, 30'd1});
        end
        ibus_wait = 1'b0;
        wait_cond(1, "ws_store_seen");
        dbus_wait = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge i_Clk);
            check_eq($sformatf("ws_st_addr%0d", k), {1'b0, o_DBus_Write, o_DBus_Address}, {2'b01, 30'h10});
            check_eq($sformatf("ws_st_data%0d", k), o_DBus_WriteData, 32'h55);
            check_eq($sformatf("ws_st_be%0d", k), {28'b0, o_DBus_ByteEn}, 32'hF);
        end
        dbus_wait = 1'b0;
        repeat (10) @(negedge i_Clk);
        check_eq("ws_fetch_gap", fc_at(1) - fc_at(0), 32'd6);
        check_eq("ws_wr_count", wr_q.size(), 32'd1);
        check_eq("ws_store_lat", wr_at(0).c - fc_at(1), 32'd5);
        check_eq("ws_next_fetch", fc_at(2) - wr_at(0).c, 32'd1);
        check_eq("ws_wr_data", wr_at(0).d, 32'h55);

        // ---------------- load extension, store lanes, ALU, branches, JALR ----------------
        clear_mem();
        dmem[32'h20] = 32'h80FF7F01;
        for (int i = 32'h40; i < 32'h50; i++) dmem[i] = 32'hDEADBEEF;
        emit(enc_i(12'h234, 5'd0, 3'd0, 5'd14, OP_IMM));
        emit(enc_s(12'h142, 5'd14, 5'd0, 3'd1));
        emit(enc_s(12'h143, 5'd14, 5'd0, 3'd0));
        for (int k = 0; k < 4; k++) begin
            emit(enc_i(12'(32'h80 + k), 5'd0, 3'd0, 5'd3, OP_LD));
            emit(enc_s(12'(32'h100 + 4 * k), 5'd3, 5'd0, 3'd2));
        end
        emit(enc_i(12'h082, 5'd0, 3'd4, 5'd3, OP_LD));
        emit(enc_s(12'h110, 5'd3, 5'd0, 3'd2));
        emit(enc_i(12'h082, 5'd0, 3'd1, 5'd3, OP_LD));
        emit(enc_s(12'h114, 5'd3, 5'd0, 3'd2));
        emit(enc_u(20'h80000, 5'd1, OP_LUI));
        emit(enc_i(12'h404, 5'd1, 3'd5, 5'd6, OP_IMM));
        emit(enc_s(12'h118, 5'd6, 5'd0, 3'd2));
        emit(enc_i(12'h004, 5'd1, 3'd5, 5'd7, OP_IMM));
        emit(enc_s(12'h11C, 5'd7, 5'd0, 3'd2));
        emit(enc_r(7'd0, 5'd0, 5'd1, 3'd2, 5'd8));
        emit(enc_s(12'h120, 5'd8, 5'd0, 3'd2));
        emit(enc_r(7'd0, 5'd0, 5'd1, 3'd3, 5'd9));
        emit(enc_s(12'h124, 5'd9, 5'd0, 3'd2));
        emit(enc_b(13'd8, 5'd0, 5'd1, 3'd6));
        emit(enc_i(12'd1, 5'd0, 3'd0, 5'd10, OP_IMM));
        emit(enc_b(13'd8, 5'd0, 5'd1, 3'd4));
        emit(enc_i(12'd2, 5'd10, 3'd0, 5'd10, OP_IMM));
        emit(enc_s(12'h128, 5'd10, 5'd0, 3'd2));
        jidx = pidx;
        emit(enc_i(12'(4 * (jidx + 3) + 1), 5'd0, 3'd0, 5'd11, OP_IMM));
        emit(enc_i(12'd0, 5'd11, 3'd0, 5'd12, OP_JALR));
        emit(enc_i(12'd7, 5'd0, 3'd0, 5'd13, OP_IMM));
        emit(enc_s(12'h12C, 5'd12, 5'd0, 3'd2));
        emit(enc_s(12'h130, 5'd13, 5'd0, 3'd2));
        emit(enc_u(20'd0, 5'd15, OP_AUIPC));
        emit(enc_s(12'h134, 5'd15, 5'd0, 3'd2));
        emit(enc_j(21'd0, 5'd0));
        do_reset();
        repeat (400) @(negedge i_Clk);
        check_eq("sh_addr", {2'b00, wr_at(0).a}, 32'h50);
        check_eq("sh_be", {28'b0, wr_at(0).be}, 32'hC);
        check_eq("sh_data", wr_at(0).d, 32'h02340234);
        check_eq("sb3_be", {28'b0, wr_at(1).be}, 32'h8);
        check_eq("sb3_data", wr_at(1).d, 32'h34343434);
        check_eq("lb_off0", dmem[32'h40], 32'h00000001);
        check_eq("lb_off1", dmem[32'h41], 32'h0000007F);
        check_eq("lb_off2", dmem[32'h42], 32'hFFFFFFFF);
        check_eq("lb_off3", dmem[32'h43], 32'hFFFFFF80);
        check_eq("lbu_off2", dmem[32'h44], 32'h000000FF);
        check_eq("lh_off2", dmem[32'h45], 32'hFFFF80FF);
        check_eq("srai", dmem[32'h46], 32'hF8000000);
        check_eq("srli", dmem[32'h47], 32'h08000000);
        check_eq("slt", dmem[32'h48], 32'h1);
        check_eq("sltu", dmem[32'h49], 32'h0);
        check_eq("bltu_nt_blt_t", dmem[32'h4A], 32'h1);
        check_eq("jalr_link", dmem[32'h4B], 32'(4 * (jidx + 2)));
        check_eq("jalr_skip", dmem[32'h4C], 32'h0);
        check_eq("jalr_bit0_clr", dmem[32'h4D], 32'(4 * (jidx + 5)));

        // ---------------- reset during a load ----------------
        clear_mem();
        dmem[32'h20] = 32'h80FF7F01;
        emit(enc_s(12'h200, 5'd5, 5'd0, 3'd2));
        emit(enc_i(12'h080, 5'd0, 3'd2, 5'd5, OP_LD));
        emit(enc_j(21'd0, 5'd0));
        do_reset();
        wait_cond(2, "rst_load1_seen");
        dbus_wait = 1'b1;
        i_Reset = 1'b1;
        #1;
        check_eq("rst_mid_dread", {31'b0, o_DBus_Read}, 32'd0);
        check_eq("rst_mid_be", {28'b0, o_DBus_ByteEn}, 32'd0);
        @(negedge i_Clk);
        i_Reset = 1'b0;
        dbus_wait = 1'b0;
        #1;
        check_eq("rst_after_dread", {31'b0, o_DBus_Read}, 32'd0);
        check_eq("rst_after_fetch", {1'b0, o_IBus_Read, o_IBus_Address}, {2'b01, INIT_PC[31:2]});
        wait_cond(2, "rst_load2_seen");
        @(negedge i_Clk);
        i_Reset = 1'b1;
        @(negedge i_Clk);
        i_Reset = 1'b0;
        clear_logs();
        repeat (30) @(negedge i_Clk);
        check_eq("rst_rd_wr_seen", {31'b0, wr_q.size() > 0}, 32'd1);
        check_eq("rst_rd_wr_addr", {2'b00, wr_at(0).a}, 32'h80);
        check_eq("rst_rd_not_written", wr_at(0).d, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
